// File: rtl/ysyx_23060187_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060187_ifu
// Brief    : Instruction fetch unit. Holds the PC, issues one memory read at
//            a time and hands instruction/PC pairs to decode.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060187_ifu #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_valid,
    output logic [XLEN-1:0]  req_addr,
    input  logic             req_ready,
    input  logic             resp_valid,
    input  logic [XLEN-1:0]  resp_data,
    output logic             inst_valid,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             inst_ready,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    output logic [31:0]      fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;

    logic [XLEN-1:0] jump_tgt;
    logic            unused_tgt_lsbs;

    // Redirect targets are forced onto a word boundary.
    assign jump_tgt        = {jump_target[XLEN-1:2], 2'b00};
    assign unused_tgt_lsbs = ^jump_target[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_cnt_d  = fetch_cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (jump) pc_d = jump_tgt;
            end
            S_REQ: begin
                if (jump) pc_d = jump_tgt;
                if (req_ready) begin
                    state_d = S_WAIT;
                    // Old address already accepted: its reply must be thrown away.
                    if (jump) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    if (jump) begin
                        pc_d    = jump_tgt;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = resp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + c_pc_step;
                        state_d      = S_HOLD;
                    end
                end else if (jump) begin
                    pc_d   = jump_tgt;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect cancels the held instruction even if decode takes it.
                if (jump) begin
                    inst_valid_d = 1'b0;
                    pc_d         = jump_tgt;
                    state_d      = S_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign req_valid  = (state_q == S_REQ);
    assign req_addr   = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060187_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060187_ifu
// Brief    : Scoreboard bench for the fetch unit with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060187_ifu;

    localparam logic [31:0] K      = 32'h1111_1111;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, resp_valid, inst_valid, inst_ready, jump;
    logic [31:0] req_addr, resp_data, inst, inst_pc, jump_target, fetch_cnt;

    ysyx_23060187_ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .jump(jump), .jump_target(jump_target), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_deliv  = 0;
    int lat_min  = 0;
    int lat_max  = 0;
    int ready_pct = 100;
    logic [31:0] exp_q[$];
    logic [31:0] acc_addr_q[$];
    int          acc_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: got no event required within budget (cycle %0d)", name, cyc);
    endtask

    // Expected delivery stream after a reset or redirect: consecutive words.
    task automatic reload(input logic [31:0] base);
        logic [31:0] b;
        b = {base[31:2], 2'b00};
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(b + 32'(4 * k));
    endtask

    task automatic redirect(input logic [31:0] tgt);
        jump = 1'b1;
        jump_target = tgt;
        reload(tgt);
        @(posedge clk); #1;
        jump = 1'b0;
    endtask

    task automatic wait_accept(input string name, output logic [31:0] a, output int c);
        int t = 0;
        a = '0;
        c = 0;
        while (acc_addr_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        if (acc_addr_q.size() == 0) timeout(name);
        else begin a = acc_addr_q.pop_front(); c = acc_cyc_q.pop_front(); end
    endtask

    task automatic wait_deliv(input string name, input int n);
        int t = 0;
        while (n_deliv < n && t < 300) begin @(negedge clk); t++; end
        if (n_deliv < n) timeout(name);
    endtask

    task automatic wait_inst_valid(input string name);
        int t = 0;
        @(negedge clk);
        while (!inst_valid && t < 200) begin @(negedge clk); t++; end
        if (!inst_valid) timeout(name);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_valid"},  32'(req_valid),  32'd0);
        check({tag, "_req_addr"},   req_addr,        RST_PC);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"},       inst,            32'd0);
        check({tag, "_inst_pc"},    inst_pc,         32'd0);
        check({tag, "_fetch_cnt"},  fetch_cnt,       32'd0);
    endtask

    // Memory: one outstanding read, reply = addr ^ K after a chosen latency.
    // A read cut off by reset comes back late as a stale word.
    initial begin : p_mem
        bit          busy;
        bit          acc;
        bit          rs;
        int          wcnt;
        int          stale;
        logic [31:0] a;
        logic [31:0] sa;
        busy = 0; wcnt = 0; stale = 0; a = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        forever begin
            @(negedge clk);
            rs  = rst;
            acc = rst && req_valid && req_ready;
            sa  = req_addr;
            @(posedge clk); #1;
            if (!rs) begin
                if (busy) begin stale = 2; busy = 0; end
                req_ready = 1'b0; resp_valid = (stale != 0); resp_data = 32'hDEAD_BEEF;
            end else if (stale != 0) begin
                stale--;
                req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
            end else begin
                if (resp_valid) begin resp_valid = 1'b0; busy = 0; end
                if (acc) begin busy = 1; a = sa; wcnt = $urandom_range(lat_max, lat_min); end
                if (busy) begin
                    req_ready = ($urandom_range(0, 1) == 1);
                    if (wcnt == 0) begin resp_valid = 1'b1; resp_data = a ^ K; end
                    else wcnt--;
                end else begin
                    req_ready = ($urandom_range(0, 99) < ready_pct);
                end
            end
        end
    end

    initial begin : p_acc_log
        forever begin
            @(negedge clk);
            if (rst && req_valid && req_ready) begin
                acc_addr_q.push_back(req_addr);
                acc_cyc_q.push_back(cyc);
                check("req_align", 32'(req_addr[1:0]), 32'd0);
            end
        end
    end

    initial begin : p_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && inst_valid && inst_ready && !jump) begin
                if (exp_q.size() == 0) timeout("scoreboard_empty");
                else begin
                    e = exp_q.pop_front();
                    check("deliv_pc", inst_pc, e);
                    check("deliv_inst", inst, e ^ K);
                end
                check("deliv_cnt", fetch_cnt, 32'(n_deliv));
                n_deliv++;
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        logic [31:0] a, a2, v_inst, v_pc, c;
        int          c0, c1, c2, t;
        bit          seen, hit;
        inst_ready = 1'b0; jump = 1'b0; jump_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst0");

        // Zero-wait memory, decode always ready
        ready_pct = 100; lat_min = 0; lat_max = 0; inst_ready = 1'b1;
        reload(RST_PC); n_deliv = 0; acc_addr_q.delete(); acc_cyc_q.delete();
        @(posedge clk); #2 rst = 1'b1;
        wait_accept("acc0", a, c0);
        check("first_req_addr", a, RST_PC);
        wait_accept("acc1", a, c1);
        wait_accept("acc2", a, c2);
        check("spacing01", 32'(c1 - c0), 32'd3);
        check("spacing12", 32'(c2 - c1), 32'd3);
        wait_deliv("deliv3", 3);
        @(posedge clk); @(negedge clk);
        check("cnt_after_3", fetch_cnt, 32'd3);

        // Backpressure in HOLD
        @(posedge clk); #1 inst_ready = 1'b0;
        wait_inst_valid("bp_valid");
        v_inst = inst; v_pc = inst_pc; c = fetch_cnt;
        repeat (5) begin
            @(negedge clk);
            check("bp_inst", inst, v_inst);
            check("bp_pc", inst_pc, v_pc);
            check("bp_req_valid", 32'(req_valid), 32'd0);
        end
        @(posedge clk); #1 inst_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_cnt", fetch_cnt, c + 32'd1);

        // Redirect while waiting on a slow memory
        lat_min = 4; lat_max = 4;
        acc_addr_q.delete(); acc_cyc_q.delete();
        wait_accept("wj_acc", a, c0);
        @(posedge clk); #1;
        acc_addr_q.delete(); acc_cyc_q.delete();
        redirect(32'h8000_0102);
        seen = 0; t = 0;
        while (acc_addr_q.size() == 0 && t < 200) begin
            @(negedge clk);
            if (inst_valid) seen = 1;
            t++;
        end
        check("wj_no_inst", 32'(seen), 32'd0);
        wait_accept("wj_acc2", a, c0);
        check("wj_req_addr", a, 32'h8000_0100);
        wait_deliv("wj_deliv", n_deliv + 1);

        // Redirect in HOLD together with inst_ready
        lat_min = 0; lat_max = 0;
        @(posedge clk); #1 inst_ready = 1'b0;
        wait_inst_valid("hj_valid");
        c = fetch_cnt;
        @(posedge clk); #1;
        inst_ready = 1'b1;
        acc_addr_q.delete(); acc_cyc_q.delete();
        redirect(32'h8000_0200);
        @(negedge clk);
        check("hj_inst_valid", 32'(inst_valid), 32'd0);
        check("hj_cnt", fetch_cnt, c);
        wait_accept("hj_acc", a, c0);
        check("hj_req_addr", a, 32'h8000_0200);

        // Redirect coincident with the response
        lat_min = 2; lat_max = 2;
        hit = 0; t = 0;
        while (!hit && t < 200) begin
            @(posedge clk); #2;
            if (resp_valid && !req_valid && !inst_valid) hit = 1;
            t++;
        end
        if (!hit) timeout("cj_resp");
        else begin
            lat_min = 0; lat_max = 0;
            acc_addr_q.delete(); acc_cyc_q.delete();
            redirect(32'h8000_0300);
            wait_accept("cj_acc", a, c0);
            check("cj_req_addr", a, 32'h8000_0300);
            wait_accept("cj_acc2", a2, c0);
            check("cj_next_addr", a2, 32'h8000_0304);
        end

        // PC wraps past the top of the address space
        @(posedge clk); #1;
        redirect(32'hFFFF_FFF9);
        wait_deliv("wrap_deliv", n_deliv + 4);

        // Reset asserted while a read is outstanding
        lat_min = 5; lat_max = 5;
        acc_addr_q.delete(); acc_cyc_q.delete();
        wait_accept("rw_acc", a, c0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst1");
        lat_min = 0; lat_max = 0;
        reload(RST_PC); n_deliv = 0;
        @(posedge clk); #2;
        acc_addr_q.delete(); acc_cyc_q.delete();
        rst = 1'b1;
        wait_accept("rr_acc", a, c0);
        check("rr_req_addr", a, RST_PC);
        wait_deliv("rr_deliv", 2);

        // Randomised traffic
        lat_min = 0; lat_max = 3; ready_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                redirect(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
        end
        @(posedge clk); #1 inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("final_cnt", fetch_cnt, 32'(n_deliv));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
